// File: rtl/assert_pkg.sv
// Shared types and helpers for the assertion-library temporal checkers.
package assert_pkg;

   typedef enum logic [1:0] {
      CHK_PASS     = 2'd0,
      CHK_TIMEOUT  = 2'd1,
      CHK_EARLY    = 2'd2,
      CHK_SPURIOUS = 2'd3
   } chk_res_e;

   localparam int CHK_CNT_W = 16;

   // Wide enough that MAX_LAT+1 ages never alias modulo 2^CNT_W.
   function automatic int chk_cnt_w(input int max_lat);
      return $clog2(max_lat + 2) + 1;
   endfunction

   function automatic logic [CHK_CNT_W-1:0] sat_add(
      input logic [CHK_CNT_W-1:0] v,
      input logic [2:0]           inc
   );
      logic [CHK_CNT_W:0] s;
      s = {1'b0, v} + (CHK_CNT_W + 1)'(inc);
      return s[CHK_CNT_W] ? '1 : s[CHK_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/assert_hist_match.sv
// Per-side history shift register, fill counter and start/end pattern compare.
module assert_hist_match
   import assert_pkg::*;
#(
   parameter int W    = 4,
   parameter int HIST = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         enable_i,
   input  logic [W-1:0] ev_i,
   input  logic [W-1:0] start_i,
   input  logic [W-1:0] end_i,
   output logic         match_o
);

   generate
      if (HIST == 0) begin : g_level
         logic unused_lvl;
         assign unused_lvl = ^{clk, reset_n, start_i};
         assign match_o    = enable_i && (ev_i == end_i);
      end else begin : g_hist
         localparam int FW = $clog2(HIST + 1);
         logic [W-1:0]  hist_q [HIST];
         logic [FW-1:0] fill_q;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               fill_q <= '0;
               for (int i = 0; i < HIST; i++) hist_q[i] <= '0;
            end else if (!enable_i) begin
               fill_q <= '0;
            end else begin
               hist_q[0] <= ev_i;
               for (int i = 1; i < HIST; i++) hist_q[i] <= hist_q[i-1];
               if (fill_q != FW'(HIST)) fill_q <= fill_q + 1'b1;
            end
         end

         assign match_o = enable_i && (fill_q == FW'(HIST)) &&
                          (ev_i == end_i) && (hist_q[HIST-1] == start_i);
      end
   endgenerate

endmodule

// File: rtl/assert_event_window_chk.sv
// A-trigger to B-response latency window checker with an in-order pending queue.
// Define ASSERT_EVENT_MSG_EN to print a message for every result or overflow.
module assert_event_window_chk
   import assert_pkg::*;
#(
   parameter  int A_W      = 4,
   parameter  int B_W      = 4,
   parameter  int A_HIST   = 1,
   parameter  int B_HIST   = 1,
   parameter  int MIN_LAT  = 1,
   parameter  int MAX_LAT  = 4,
   parameter  int MAX_PEND = 4,
   localparam int CNT_W    = chk_cnt_w(MAX_LAT),
   localparam int PC_W     = $clog2(MAX_PEND + 1)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [A_W-1:0]       event_a,
   input  logic [A_W-1:0]       a_start,
   input  logic [A_W-1:0]       a_end,
   input  logic [B_W-1:0]       event_b,
   input  logic [B_W-1:0]       b_start,
   input  logic [B_W-1:0]       b_end,
   output logic                 res_valid,
   output logic [1:0]           res_code,
   output logic [CNT_W-1:0]     res_lat,
   output logic                 overflow,
   output logic [PC_W-1:0]      pend_cnt,
   output logic [CHK_CNT_W-1:0] pass_cnt,
   output logic [CHK_CNT_W-1:0] fail_cnt,
   output logic                 sticky_fail
);

   localparam int PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
   localparam logic [CNT_W-1:0] MAXL = CNT_W'(MAX_LAT);
   localparam logic [CNT_W-1:0] MINL = CNT_W'(MIN_LAT);
   localparam logic [PC_W-1:0]  FULL = PC_W'(MAX_PEND);

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(MAX_PEND - 1)) ? '0 : p + 1'b1;
   endfunction

   logic a_match, b_match;

   assert_hist_match #(.W(A_W), .HIST(A_HIST)) u_hist_a (
      .clk(clk), .reset_n(reset_n), .enable_i(enable),
      .ev_i(event_a), .start_i(a_start), .end_i(a_end),
      .match_o(a_match)
   );

   assert_hist_match #(.W(B_W), .HIST(B_HIST)) u_hist_b (
      .clk(clk), .reset_n(reset_n), .enable_i(enable),
      .ev_i(event_b), .start_i(b_start), .end_i(b_end),
      .match_o(b_match)
   );

   logic [CNT_W-1:0]     stamp_q [MAX_PEND];
   logic [CNT_W-1:0]     now_q;
   logic [PW-1:0]        head_q, head_d, tail_q, tail_d, head_n;
   logic [PC_W-1:0]      cnt_q, cnt_d;
   logic                 rv_q, rv_d, ovf_q, ovf_d, sticky_q, sticky_d;
   chk_res_e             code_q, code_d;
   logic [CNT_W-1:0]     lat_q, lat_d;
   logic [CHK_CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;

   logic [CNT_W-1:0] age0, age1, b_age;
   logic             tmo, bh_ok, b_hit, b_spur, b_pass, b_early;
   logic             push;
   logic [1:0]       pops;
   logic [2:0]       fail_inc;

   always_comb begin
      head_n  = nxt(head_q);
      age0    = now_q - stamp_q[head_q];
      age1    = now_q - stamp_q[head_n];
      tmo     = enable && (cnt_q != '0) && (age0 > MAXL);
      // After a timeout pop, B is judged against the following entry.
      bh_ok   = tmo ? (cnt_q > PC_W'(1)) : (cnt_q != '0);
      b_age   = tmo ? age1 : age0;
      b_hit   = enable && b_match && bh_ok;
      b_spur  = enable && b_match && !bh_ok;
      b_pass  = b_hit && (b_age >= MINL);
      b_early = b_hit && (b_age < MINL);
      pops    = {1'b0, tmo} + {1'b0, b_hit};
      ovf_d   = enable && a_match && (cnt_q == FULL) && (pops == 2'd0);
      push    = enable && a_match && !ovf_d;

      head_d = head_q;
      if (pops != 2'd0) head_d = head_n;
      if (pops == 2'd2) head_d = nxt(head_n);
      tail_d = push ? nxt(tail_q) : tail_q;
      cnt_d  = cnt_q + PC_W'(push) - PC_W'(pops);
      if (!enable) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end

      rv_d   = tmo || b_hit || b_spur;
      code_d = CHK_PASS;
      lat_d  = '0;
      if (tmo) begin
         code_d = CHK_TIMEOUT;
         lat_d  = age0;
      end else if (b_hit) begin
         code_d = b_pass ? CHK_PASS : CHK_EARLY;
         lat_d  = b_age;
      end else if (b_spur) begin
         code_d = CHK_SPURIOUS;
      end

      fail_inc = {2'b0, tmo} + {2'b0, b_early} +
                 {2'b0, b_spur} + {2'b0, ovf_d};
      pass_d   = sat_add(pass_q, {2'b0, b_pass});
      fail_d   = sat_add(fail_q, fail_inc);
      sticky_d = sticky_q | (fail_inc != 3'd0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         now_q    <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         cnt_q    <= '0;
         rv_q     <= 1'b0;
         ovf_q    <= 1'b0;
         code_q   <= CHK_PASS;
         lat_q    <= '0;
         pass_q   <= '0;
         fail_q   <= '0;
         sticky_q <= 1'b0;
         for (int i = 0; i < MAX_PEND; i++) stamp_q[i] <= '0;
      end else begin
         now_q    <= now_q + 1'b1;
         head_q   <= head_d;
         tail_q   <= tail_d;
         cnt_q    <= cnt_d;
         rv_q     <= rv_d;
         ovf_q    <= ovf_d;
         code_q   <= code_d;
         lat_q    <= lat_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         sticky_q <= sticky_d;
         if (push) stamp_q[tail_q] <= now_q;
      end
   end

   assign res_valid   = rv_q;
   assign res_code    = code_q;
   assign res_lat     = lat_q;
   assign overflow    = ovf_q;
   assign pend_cnt    = cnt_q;
   assign pass_cnt    = pass_q;
   assign fail_cnt    = fail_q;
   assign sticky_fail = sticky_q;

`ifdef ASSERT_EVENT_MSG_EN
   always_ff @(posedge clk) begin
      if (rv_q && code_q == CHK_PASS)
         $display("%0t: event_window PASS lat=%0d a=%h->%h b=%h->%h",
                  $time, lat_q, a_start, a_end, b_start, b_end);
      else if (rv_q)
         $error("%0t: event_window %s lat=%0d a=%h->%h b=%h->%h",
                $time, code_q.name(), lat_q, a_start, a_end, b_start, b_end);
      if (ovf_q)
         $error("%0t: event_window overflow a=%h->%h b=%h->%h",
                $time, a_start, a_end, b_start, b_end);
   end
`endif

endmodule

// File: tb/tb_assert_event_window_chk.sv
// Directed bench for assert_event_window_chk with a queue-based reference model.
module tb_assert_event_window_chk;

   localparam int A_W = 4, B_W = 4, A_HIST = 1, B_HIST = 1;
   localparam int MIN_LAT = 2, MAX_LAT = 4, MAX_PEND = 2;
   localparam int CNT_W = 4, PC_W = 2;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             enable = 1'b1;
   logic [A_W-1:0]   event_a = '0, a_start = 4'd0, a_end = 4'd1;
   logic [B_W-1:0]   event_b = '0, b_start = 4'd3, b_end = 4'd4;
   logic             res_valid, overflow, sticky_fail;
   logic [1:0]       res_code;
   logic [CNT_W-1:0] res_lat;
   logic [PC_W-1:0]  pend_cnt;
   logic [15:0]      pass_cnt, fail_cnt;

   assert_event_window_chk #(
      .A_W(A_W), .B_W(B_W), .A_HIST(A_HIST), .B_HIST(B_HIST),
      .MIN_LAT(MIN_LAT), .MAX_LAT(MAX_LAT), .MAX_PEND(MAX_PEND)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .event_a(event_a), .a_start(a_start), .a_end(a_end),
      .event_b(event_b), .b_start(b_start), .b_end(b_end),
      .res_valid(res_valid), .res_code(res_code), .res_lat(res_lat),
      .overflow(overflow), .pend_cnt(pend_cnt),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .sticky_fail(sticky_fail)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;

   // Reference model: edge-indexed trigger stamps in a queue.
   int       q[$];
   int       t, fa, fb;
   logic [3:0] pa, pb;
   bit       e_rv, e_ovf, e_sticky;
   int       e_code, e_lat, e_pend, e_pass, e_fail;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      t = 0; fa = 0; fb = 0; pa = '0; pb = '0;
      e_rv = 0; e_ovf = 0; e_sticky = 0;
      e_code = 0; e_lat = 0; e_pend = 0; e_pass = 0; e_fail = 0;
   endtask

   task automatic model_edge();
      bit am, bm;
      int pinc, finc, pops, lat;
      e_rv = 0; e_code = 0; e_lat = 0; e_ovf = 0;
      pinc = 0; finc = 0; pops = 0;
      if (!enable) begin
         q.delete(); fa = 0; fb = 0; e_pend = 0; t++;
         return;
      end
      am = (fa >= A_HIST) && (event_a == a_end) && (pa == a_start);
      bm = (fb >= B_HIST) && (event_b == b_end) && (pb == b_start);
      pa = event_a; pb = event_b;
      if (fa < A_HIST) fa++;
      if (fb < B_HIST) fb++;
      if (q.size() > 0 && t - q[0] > MAX_LAT) begin
         e_rv = 1; e_code = 1; e_lat = t - q[0];
         void'(q.pop_front()); finc++; pops++;
      end
      if (bm) begin
         if (q.size() > 0) begin
            lat = t - q[0];
            void'(q.pop_front()); pops++;
            if (lat >= MIN_LAT) pinc = 1; else finc++;
            if (!e_rv) begin
               e_rv = 1; e_code = (lat >= MIN_LAT) ? 0 : 2; e_lat = lat;
            end
         end else begin
            finc++;
            if (!e_rv) begin e_rv = 1; e_code = 3; e_lat = 0; end
         end
      end
      if (am) begin
         if (q.size() == MAX_PEND && pops == 0) begin
            e_ovf = 1; finc++;
         end else q.push_back(t);
      end
      e_pass = (e_pass + pinc > 65535) ? 65535 : e_pass + pinc;
      e_fail = (e_fail + finc > 65535) ? 65535 : e_fail + finc;
      if (finc > 0) e_sticky = 1;
      e_pend = q.size();
      t++;
   endtask

   task automatic compare_all();
      chk("res_valid", res_valid, e_rv);
      if (e_rv) begin
         chk("res_code", res_code, e_code);
         chk("res_lat", res_lat, e_lat);
      end
      chk("overflow", overflow, e_ovf);
      chk("pend_cnt", pend_cnt, e_pend);
      chk("pass_cnt", pass_cnt, e_pass);
      chk("fail_cnt", fail_cnt, e_fail);
      chk("sticky_fail", sticky_fail, e_sticky);
   endtask

   task automatic ed(input logic [3:0] a, input logic [3:0] b);
      event_a = a; event_b = b;
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) ed(4'd0, 4'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; enable = 1'b1; event_a = '0; event_b = '0;
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic pats(input logic [3:0] as, ae, bs, be);
      a_start = as; a_end = ae; b_start = bs; b_end = be;
   endtask

   initial begin
      // Reset state.
      do_reset();
      chk("rst_pend", pend_cnt, 0);
      chk("rst_fail", fail_cnt, 0);

      // PASS: A at edge 10, B at edge 13.
      idle(9); ed(4'd1, 4'd0); ed(4'd0, 4'd0); ed(4'd0, 4'd3); ed(4'd0, 4'd4);
      chk("pass_valid", res_valid, 1);
      chk("pass_code", res_code, 0);
      chk("pass_lat", res_lat, 3);
      chk("pass_cnt1", pass_cnt, 1);
      idle(3);

      // TIMEOUT at edge 15.
      do_reset();
      idle(9); ed(4'd1, 4'd0); idle(5);
      chk("tmo_code", res_code, 1);
      chk("tmo_lat", res_lat, 5);
      chk("tmo_sticky", sticky_fail, 1);
      chk("tmo_fail", fail_cnt, 1);
      idle(2);

      // EARLY then SPURIOUS.
      do_reset();
      idle(9); ed(4'd1, 4'd3); ed(4'd0, 4'd4);
      chk("early_code", res_code, 2);
      chk("early_lat", res_lat, 1);
      idle(6); ed(4'd0, 4'd3); ed(4'd0, 4'd4);
      chk("spur_code", res_code, 3);
      chk("spur_lat", res_lat, 0);
      chk("spur_fail", fail_cnt, 2);
      idle(2);

      // Overflow with a two-entry queue, then two PASS results.
      do_reset();
      pats(4'd5, 4'd5, 4'd7, 4'd7);
      idle(8); ed(4'd5, 4'd0); ed(4'd5, 4'd0); ed(4'd5, 4'd0); ed(4'd5, 4'd7);
      chk("ovf_pulse", overflow, 1);
      chk("ovf_pend", pend_cnt, 2);
      ed(4'd0, 4'd7);
      chk("ovf_p1_code", res_code, 0);
      chk("ovf_p1_lat", res_lat, 3);
      ed(4'd0, 4'd7);
      chk("ovf_p2_lat", res_lat, 3);
      chk("ovf_pass", pass_cnt, 2);
      chk("ovf_pend0", pend_cnt, 0);
      pats(4'd0, 4'd1, 4'd3, 4'd4);
      idle(2);

      // Same-edge A and B on an empty queue, then disable flush.
      do_reset();
      idle(8); ed(4'd0, 4'd3); ed(4'd1, 4'd4);
      chk("same_code", res_code, 3);
      chk("same_pend", pend_cnt, 1);
      enable = 1'b0;
      ed(4'd0, 4'd0);
      chk("dis_pend", pend_cnt, 0);
      chk("dis_valid", res_valid, 0);
      chk("dis_fail", fail_cnt, 1);
      enable = 1'b1;
      idle(8);

      // Reset mid-window with two entries pending.
      do_reset();
      pats(4'd5, 4'd5, 4'd7, 4'd7);
      idle(8); ed(4'd5, 4'd0); ed(4'd5, 4'd0); ed(4'd5, 4'd0); ed(4'd0, 4'd0);
      chk("mid_pend2", pend_cnt, 2);
      reset_n = 1'b0;
      #1;
      chk("mid_valid", res_valid, 0);
      chk("mid_pend", pend_cnt, 0);
      chk("mid_ovf", overflow, 0);
      chk("mid_sticky", sticky_fail, 0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      pats(4'd0, 4'd1, 4'd3, 4'd4);
      idle(8);
      chk("post_rst_fail", fail_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/assert_event_window_chk.md
# assert_event_window_chk

Parametrised, synthesisable temporal checker for the assertion library. It detects a trigger transition on signal A and requires a matching transition on signal B within a latency window [MIN_LAT, MAX_LAT] cycles. Up to MAX_PEND triggers may be outstanding at once, and they are checked in order. Results are reported as registered pulses, saturating counters and a sticky fail flag, so the checker can be bound into RTL, simulation or emulation alike.

## Interface
- A_W, 4: width of event_a and its start/end patterns
- B_W, 4: width of event_b and its start/end patterns
- A_HIST, 1: cycles between the start and end samples of A; 0 means level match on end only
- B_HIST, 1: the same for B
- MIN_LAT, 1: minimum trigger-to-response latency in cycles; must be ≥1
- MAX_LAT, 4: maximum latency; must be ≥ MIN_LAT
- MAX_PEND, 4: outstanding-trigger queue depth; must be ≥1
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  checker active
- event_a, a_start, a_end  in  A_W each  trigger signal and its patterns
- event_b, b_start, b_end  in  B_W each  response signal and its patterns
- res_valid  out  1  one-cycle result strobe
- res_code  out  2  result code: PASS=0, TIMEOUT=1, EARLY=2, SPURIOUS=3
- res_lat  out  CNT_W  measured latency for PASS and EARLY; MAX_LAT+1 for TIMEOUT; 0 for SPURIOUS
- overflow  out  1  one-cycle pulse when a trigger is dropped because the queue is full
- pend_cnt  out  $clog2(MAX_PEND+1)  number of outstanding triggers
- pass_cnt, fail_cnt  out  16 each  saturating counters
- sticky_fail  out  1  set on any non-PASS result or on overflow

## Operation
- History: each side has a shift register of depth *_HIST and a fill counter.
  - The side is valid only after *_HIST enabled cycles have elapsed since reset.
- Match conditions, evaluated only while the side is valid:
  - A-match = (event_a == a_end) && (hist_a[A_HIST-1] == a_start).
  - B-match is defined the same way with the B signals.
- Free-running timestamp counter `now` has width CNT_W = $clog2(MAX_LAT+2)+1. Age = now − stamp, computed modulo 2^CNT_W.
- Each edge, in priority order, looking only at the oldest queue entry (head):
  1. Head present and age > MAX_LAT → pop, TIMEOUT. A B-match on the same edge is then checked against the new head.
  2. B-match and head present:
     - age ≥ MIN_LAT → pop, PASS.
     - Otherwise → pop, EARLY.
  3. B-match with the queue empty → SPURIOUS.
  4. A-match → push `now`. If the queue is full and no pop occurred this edge → drop the trigger and pulse overflow.
- At most one result is reported per edge. If a TIMEOUT and a B result coincide, TIMEOUT is reported and the B result is counted in the counters only.
- A trigger is always pushed after evaluation, so a B-match on the same edge never matches that new trigger.
- pass_cnt increments on PASS. fail_cnt increments on TIMEOUT, EARLY, SPURIOUS and overflow. Both counters saturate at 16'hFFFF.
- enable low:
  - Queue flushed with no result reported.
  - History fill counters cleared.
  - Counters and sticky_fail hold.
- Reset mid-operation: queue, history, counters and `now` cleared asynchronously. Any pending results are discarded.

## Timing
- All outputs are registered. The result of edge N is visible after edge N.
- Latency L = B-edge index − A-edge index. With MIN_LAT=2 and MAX_LAT=4, the pass window is L ∈ {2,3,4}.
- TIMEOUT is reported at the edge where the age first reaches MAX_LAT+1.
- Reset values: res_valid=0, res_code=0, res_lat=0, overflow=0, pend_cnt=0, pass_cnt=0, fail_cnt=0, sticky_fail=0.
- Width rule: MAX_LAT < 2^(CNT_W−1), so modulo age arithmetic never aliases.

## Configuration
- ASSERT_EVENT_MSG_EN:
  - Defined: on every res_valid or overflow, print $display for PASS, or $error for any failure. The message includes $time, the code, the latency and the patterns.
  - Undefined: no system tasks are compiled and the block is fully synthesisable.
  - Signal behaviour is identical in both cases.

## Structure
- Package assert_pkg:
  - enum chk_res_e {CHK_PASS, CHK_TIMEOUT, CHK_EARLY, CHK_SPURIOUS}.
  - Saturating-counter width constant CHK_CNT_W=16.
  - CNT_W derivation function.
- Sub-module assert_hist_match #(W, HIST): shift register, fill counter and start/end compare. Instantiated once for A and once for B.
- The queue is an inline circular buffer of stamps with head/tail pointers.

## Test plan
- MIN=2, MAX=4, HIST=1. A goes 0→1 at edge 10, B goes 3→4 at edge 13 → PASS, res_lat=3, pass_cnt=1.
- Same setup with no B transition → TIMEOUT at edge 15, res_lat=5, sticky_fail=1, fail_cnt=1.
- A at edge 10, B at edge 11 → EARLY, res_lat=1. Separately, B with no pending trigger → SPURIOUS.
- MAX_PEND=2, A-matches at edges 10, 11 and 12 with no pop → overflow pulse at edge 12, pend_cnt=2. Then B at edges 13 and 14 → two PASS results with res_lat 3 and 3.
- A-match and B-match on the same edge with an empty queue → SPURIOUS reported and pend_cnt=1. Deassert enable → pend_cnt=0 with no result.
- Assert reset_n low mid-window with two entries pending → all outputs return to 0 immediately, and no result appears after reset is released.
